seq_bus_ring_ctrl: RTL

Controller for the sequence-packet bus token ring. Dispatches incoming match jobs round-robin to NUM_NODES match-engine lanes. Owns the single ring token: injects it into node 0 and takes it back from the last node. Tracks outstanding jobs by watching eoj beats on the bus output, and exposes status and sticky error flags. Every ring node is instantiated with FIRST=0; this block is the only token source.

---
 rtl/seq_bus_ring_ctrl_if.sv | 32 +++
 rtl/seq_bus_ring_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/seq_bus_ring_ctrl_if.sv
// Handshake bundle between the ring controller and its environment.
// Covers the job request, lane fan-out, ring token and bus monitor signals.
interface seq_bus_ring_ctrl_if #(
  parameter int NUM_NODES = 4,
  parameter int JOB_W     = 64
);
  logic                 job_i_valid;
  logic [JOB_W-1:0]     job_i_data;
  logic                 job_i_ready;
  logic [NUM_NODES-1:0] job_o_valid;
  logic [JOB_W-1:0]     job_o_data;
  logic [NUM_NODES-1:0] job_o_ready;
  logic                 tok_inj_valid;
  logic                 tok_inj_ready;
  logic                 tok_ret_valid;
  logic                 tok_ret_ready;
  logic                 mon_valid;
  logic                 mon_ready;
  logic                 mon_eoj;

  modport master (
    input  job_i_valid, job_i_data, job_o_ready, tok_inj_ready,
           tok_ret_valid, mon_valid, mon_ready, mon_eoj,
    output job_i_ready, job_o_valid, job_o_data, tok_inj_valid, tok_ret_ready
  );

  modport slave (
    output job_i_valid, job_i_data, job_o_ready, tok_inj_ready,
           tok_ret_valid, mon_valid, mon_ready, mon_eoj,
    input  job_i_ready, job_o_valid, job_o_data, tok_inj_valid, tok_ret_ready
  );
endinterface

// File: rtl/seq_bus_ring_ctrl.sv
// Token ring controller: round-robin job dispatch to lanes, ownership of the
// single ring token, outstanding-job tracking and sticky error flags.
module seq_bus_ring_ctrl #(
  parameter int NUM_NODES       = 4,
  parameter int NODE_BITS       = 2,
  parameter int JOB_W           = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OUT_BITS        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_bus_ring_ctrl_if.master  bus,
  output logic [OUT_BITS-1:0]  outstanding,
  output logic [31:0]          jobs_done,
  output logic [NODE_BITS-1:0] rr_ptr,
  output logic                 idle,
  output logic                 err_underflow,
  output logic                 err_token
);

  localparam logic [NODE_BITS-1:0] LAST_LANE = NODE_BITS'(NUM_NODES - 1);
  localparam logic [OUT_BITS-1:0]  MAX_CNT   = OUT_BITS'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {HOLD, INJECT, CIRC} state_t;

  state_t           state;
  state_t           state_next;
  logic             full;
  logic             dispatch;
  logic             ret;
  logic [JOB_W-1:0] job_data;

  assign job_data       = bus.job_i_data;
  assign bus.job_o_data = job_data;

  // Full is taken from the registered count, so a same-cycle retire never frees a slot early
  assign full            = (outstanding == MAX_CNT);
  assign bus.job_i_ready = bus.job_o_ready[rr_ptr] & ~full;
  assign dispatch        = bus.job_i_valid & bus.job_i_ready;
  assign ret             = bus.mon_valid & bus.mon_ready & bus.mon_eoj;

  always_comb begin
    bus.job_o_valid         = '0;
    bus.job_o_valid[rr_ptr] = bus.job_i_valid & ~full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      outstanding   <= '0;
      jobs_done     <= '0;
      err_underflow <= 1'b0;
      err_token     <= 1'b0;
    end else begin
      if (dispatch)
        rr_ptr <= (rr_ptr == LAST_LANE) ? '0 : rr_ptr + NODE_BITS'(1);
      if (dispatch && !ret)
        outstanding <= outstanding + OUT_BITS'(1);
      else if (ret && !dispatch && outstanding != '0)
        outstanding <= outstanding - OUT_BITS'(1);
      if (ret)
        jobs_done <= jobs_done + 32'd1;
      if (ret && outstanding == '0)
        err_underflow <= 1'b1;
      if (bus.tok_ret_valid && state != CIRC)
        err_token <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HOLD;
    else        state <= state_next;
  end

  // A token arriving outside CIRC is flagged but never accepted
  always_comb begin
    state_next = state;
    case (state)
      HOLD:    if (outstanding != '0) state_next = INJECT;
      INJECT:  if (bus.tok_inj_ready) state_next = CIRC;
      CIRC:    if (bus.tok_ret_valid) state_next = HOLD;
      default: state_next = HOLD;
    endcase
  end

  always_comb begin
    bus.tok_inj_valid = (state == INJECT);
    bus.tok_ret_ready = (state == CIRC);
    idle              = (state == HOLD) && (outstanding == '0);
  end

endmodule
